// File: rtl/raster_counter_pkg.sv
// Shared types and constants for the raster position counter.
// The optional frame counter is enabled by defining RASTER_COUNTER_FRAME_CNT_EN.
package raster_counter_pkg;

  localparam int COL_WIDTH_DEF       = 11;
  localparam int ROW_WIDTH_DEF       = 11;
  localparam int FRAME_CNT_WIDTH_DEF = 16;

  localparam int SAT_MODE_WRAP = 0;
  localparam int SAT_MODE_HOLD = 1;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } border_flags_t;

endpackage

// File: rtl/raster_counter_if.sv
// Control, limit and position/marker signals of the raster counter.
// frame_cnt_o exists only when RASTER_COUNTER_FRAME_CNT_EN is defined.
interface raster_counter_if
  import raster_counter_pkg::*;
#(
  parameter int COL_WIDTH_P       = COL_WIDTH_DEF,
  parameter int ROW_WIDTH_P       = ROW_WIDTH_DEF,
  parameter int FRAME_CNT_WIDTH_P = FRAME_CNT_WIDTH_DEF
) ();

  logic                   en_i;
  logic                   clr_i;
  logic [COL_WIDTH_P-1:0] col_max_i;
  logic [ROW_WIDTH_P-1:0] row_max_i;
  logic [COL_WIDTH_P-1:0] col_o;
  logic [ROW_WIDTH_P-1:0] row_o;
  logic                   sol_o;
  logic                   eol_o;
  logic                   sof_o;
  logic                   eof_o;
  logic                   frame_done_o;
  logic                   done_o;
`ifdef RASTER_COUNTER_FRAME_CNT_EN
  logic [FRAME_CNT_WIDTH_P-1:0] frame_cnt_o;
`endif

  modport master (
    output en_i, clr_i, col_max_i, row_max_i,
    input  col_o, row_o, sol_o, eol_o, sof_o, eof_o, frame_done_o, done_o
`ifdef RASTER_COUNTER_FRAME_CNT_EN
    , input frame_cnt_o
`endif
  );

  modport slave (
    input  en_i, clr_i, col_max_i, row_max_i,
    output col_o, row_o, sol_o, eol_o, sof_o, eof_o, frame_done_o, done_o
`ifdef RASTER_COUNTER_FRAME_CNT_EN
    , output frame_cnt_o
`endif
  );

endinterface

// File: rtl/raster_counter_axis.sv
// One axis of the raster counter: counts 0..limit_i and wraps to 0 on en_i at the limit.
module axis_counter #(
  parameter int WIDTH_P = 11
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [WIDTH_P-1:0] limit_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               at_limit_o
);

  logic [WIDTH_P-1:0] count_q, count_d;

  assign at_limit_o = (count_q == limit_i);
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = at_limit_o ? '0 : count_q + WIDTH_P'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/raster_counter.sv
// Column/row raster position counter with line/frame markers and frame-done pulse.
// Define RASTER_COUNTER_FRAME_CNT_EN to add the frame counter output.
module raster_counter
  import raster_counter_pkg::*;
#(
  parameter int COL_WIDTH_P       = COL_WIDTH_DEF,
  parameter int ROW_WIDTH_P       = ROW_WIDTH_DEF,
  parameter int SATURATE_P        = SAT_MODE_WRAP,
  parameter int FRAME_CNT_WIDTH_P = FRAME_CNT_WIDTH_DEF
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  raster_counter_if.slave bus
);

  localparam bit HoldMode = (SATURATE_P == SAT_MODE_HOLD);

  logic [COL_WIDTH_P-1:0] col_lim_q, col_lim_d, col;
  logic [ROW_WIDTH_P-1:0] row_lim_q, row_lim_d, row;
  logic                   frame_done_q, frame_done_d;
  logic                   done_q, done_d;
  logic                   col_at_lim, row_at_lim, at_eof;
  logic                   hold, col_en, row_en, frame_wrap;
  border_flags_t          flags;

  assign at_eof = col_at_lim && row_at_lim;
  // In hold mode the pixel at eof freezes the counters instead of wrapping them.
  assign hold       = HoldMode ? (done_q || at_eof) : 1'b0;
  assign col_en     = bus.en_i && !hold;
  assign row_en     = col_en && col_at_lim;
  assign frame_wrap = bus.en_i && !done_q && at_eof;

  axis_counter #(.WIDTH_P(COL_WIDTH_P)) u_col (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (bus.clr_i),
    .en_i       (col_en),
    .limit_i    (col_lim_q),
    .count_o    (col),
    .at_limit_o (col_at_lim)
  );

  axis_counter #(.WIDTH_P(ROW_WIDTH_P)) u_row (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (bus.clr_i),
    .en_i       (row_en),
    .limit_i    (row_lim_q),
    .count_o    (row),
    .at_limit_o (row_at_lim)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    col_lim_d    = col_lim_q;
    row_lim_d    = row_lim_q;
    done_d       = done_q;
    frame_done_d = frame_wrap;
    if (bus.clr_i) begin
      col_lim_d    = bus.col_max_i;
      row_lim_d    = bus.row_max_i;
      done_d       = 1'b0;
      frame_done_d = 1'b0;
    end else if (frame_wrap) begin
      if (HoldMode) begin
        done_d = 1'b1;
      end else begin
        col_lim_d = bus.col_max_i;
        row_lim_d = bus.row_max_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      col_lim_q    <= bus.col_max_i;
      row_lim_q    <= bus.row_max_i;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      col_lim_q    <= col_lim_d;
      row_lim_q    <= row_lim_d;
      frame_done_q <= frame_done_d;
      done_q       <= done_d;
    end
  end

`ifdef RASTER_COUNTER_FRAME_CNT_EN
  logic [FRAME_CNT_WIDTH_P-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (bus.clr_i)       frame_cnt_d = '0;
    else if (frame_wrap) frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH_P'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) frame_cnt_q <= '0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign bus.frame_cnt_o = frame_cnt_q;
`endif

  always_comb begin
    flags.sol = (col == '0);
    flags.eol = col_at_lim;
    flags.sof = (col == '0) && (row == '0);
    flags.eof = at_eof;
  end

  assign bus.col_o        = col;
  assign bus.row_o        = row;
  assign bus.sol_o        = flags.sol;
  assign bus.eol_o        = flags.eol;
  assign bus.sof_o        = flags.sof;
  assign bus.eof_o        = flags.eof;
  assign bus.frame_done_o = frame_done_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_raster_counter.sv
// Directed bench for raster_counter: wrap-mode DUT checked against a small position model,
// hold-mode DUT checked against a hand-written table.
module tb_raster_counter;
  import raster_counter_pkg::*;

  localparam int CW  = 11;
  localparam int RW  = 11;
  localparam int FCW = 2;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  // Expected wrap-mode state
  logic [CW-1:0]  e_col, e_clim;
  logic [RW-1:0]  e_row, e_rlim;
  logic           e_fd;
  logic [FCW-1:0] e_fcnt;

  // Hold-mode DUT, limits (1,1), six en_i pulses
  int sat_col  [6] = '{1, 0, 1, 1, 1, 1};
  int sat_row  [6] = '{0, 1, 1, 1, 1, 1};
  int sat_done [6] = '{0, 0, 0, 1, 1, 1};
  int sat_fd   [6] = '{0, 0, 0, 1, 0, 0};

  raster_counter_if #(.COL_WIDTH_P(CW), .ROW_WIDTH_P(RW), .FRAME_CNT_WIDTH_P(FCW)) m ();
  raster_counter_if #(.COL_WIDTH_P(CW), .ROW_WIDTH_P(RW), .FRAME_CNT_WIDTH_P(FCW)) s ();

  raster_counter #(
    .COL_WIDTH_P(CW), .ROW_WIDTH_P(RW), .SATURATE_P(SAT_MODE_WRAP), .FRAME_CNT_WIDTH_P(FCW)
  ) u_dut_wrap (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (m)
  );

  raster_counter #(
    .COL_WIDTH_P(CW), .ROW_WIDTH_P(RW), .SATURATE_P(SAT_MODE_HOLD), .FRAME_CNT_WIDTH_P(FCW)
  ) u_dut_hold (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance the wrap-mode model by one edge, clock the DUTs, then compare.
  task automatic tick(input string tag);
    e_fd = 1'b0;
    if (!rstn || m.clr_i) begin
      e_col  = '0;
      e_row  = '0;
      e_clim = m.col_max_i;
      e_rlim = m.row_max_i;
      e_fcnt = '0;
    end else if (m.en_i) begin
      if (e_col == e_clim) begin
        e_col = '0;
        if (e_row == e_rlim) begin
          e_row  = '0;
          e_fd   = 1'b1;
          e_clim = m.col_max_i;
          e_rlim = m.row_max_i;
          e_fcnt = e_fcnt + FCW'(1);
        end else begin
          e_row = e_row + RW'(1);
        end
      end else begin
        e_col = e_col + CW'(1);
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".col"}, 32'(m.col_o), 32'(e_col));
    check({tag, ".row"}, 32'(m.row_o), 32'(e_row));
    check({tag, ".sol"}, 32'(m.sol_o), 32'(e_col == '0));
    check({tag, ".eol"}, 32'(m.eol_o), 32'(e_col == e_clim));
    check({tag, ".sof"}, 32'(m.sof_o), 32'(e_col == '0 && e_row == '0));
    check({tag, ".eof"}, 32'(m.eof_o), 32'(e_col == e_clim && e_row == e_rlim));
    check({tag, ".fd"},  32'(m.frame_done_o), 32'(e_fd));
    check({tag, ".done"}, 32'(m.done_o), 32'd0);
`ifdef RASTER_COUNTER_FRAME_CNT_EN
    check({tag, ".fcnt"}, 32'(m.frame_cnt_o), 32'(e_fcnt));
`endif
  endtask

  initial begin
    e_col = '0; e_row = '0; e_clim = '0; e_rlim = '0; e_fd = 1'b0; e_fcnt = '0;
    m.en_i = 1'b0; m.clr_i = 1'b0; m.col_max_i = CW'(3); m.row_max_i = RW'(2);
    s.en_i = 1'b0; s.clr_i = 1'b0; s.col_max_i = CW'(1); s.row_max_i = RW'(1);
    rstn = 1'b0;

    // Reset state
    tick("reset");
    check("reset.hold_col", 32'(s.col_o), 32'd0);
    check("reset.hold_done", 32'(s.done_o), 32'd0);
    rstn = 1'b1;

    // Full 4x3 frame, then idle
    m.en_i = 1'b1;
    for (int i = 0; i < 12; i++) tick("t1");
    check("t1.wrap_col", 32'(m.col_o), 32'd0);
    check("t1.wrap_row", 32'(m.row_o), 32'd0);
    check("t1.wrap_fd", 32'(m.frame_done_o), 32'd1);
    m.en_i = 1'b0;
    tick("t1.idle");
    check("t1.idle_fd", 32'(m.frame_done_o), 32'd0);

    // Limit change mid-frame takes effect only after the wrap
    m.en_i = 1'b1;
    repeat (5) tick("t2.pre");
    check("t2.mid_col", 32'(m.col_o), 32'd1);
    check("t2.mid_row", 32'(m.row_o), 32'd1);
    m.col_max_i = CW'(5);
    repeat (2) tick("t2.old");
    check("t2.old_eol_at3", 32'(m.eol_o), 32'd1);
    repeat (5) tick("t2.old");
    check("t2.wrap_fd", 32'(m.frame_done_o), 32'd1);
    repeat (5) tick("t2.new");
    check("t2.new_col5", 32'(m.col_o), 32'd5);
    check("t2.new_eol", 32'(m.eol_o), 32'd1);
    tick("t2.new");
    check("t2.new_wrap_row", 32'(m.row_o), 32'd1);

    // Hold mode on the second DUT, wrap-mode DUT idle
    m.en_i = 1'b0;
    s.en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("t3.idle");
      check($sformatf("t3.col%0d", i),  32'(s.col_o), 32'(sat_col[i]));
      check($sformatf("t3.row%0d", i),  32'(s.row_o), 32'(sat_row[i]));
      check($sformatf("t3.done%0d", i), 32'(s.done_o), 32'(sat_done[i]));
      check($sformatf("t3.fd%0d", i),   32'(s.frame_done_o), 32'(sat_fd[i]));
    end
    s.en_i = 1'b0;
    s.clr_i = 1'b1;
    tick("t3.idle");
    check("t3.clr_col", 32'(s.col_o), 32'd0);
    check("t3.clr_row", 32'(s.row_o), 32'd0);
    check("t3.clr_done", 32'(s.done_o), 32'd0);
    s.clr_i = 1'b0;

    // clr_i beats en_i; reset mid-frame
    m.col_max_i = CW'(3);
    m.row_max_i = RW'(2);
    m.clr_i = 1'b1;
    tick("t4.clr0");
    m.clr_i = 1'b0;
    m.en_i = 1'b1;
    repeat (6) tick("t4.run");
    check("t4.pos_col", 32'(m.col_o), 32'd2);
    check("t4.pos_row", 32'(m.row_o), 32'd1);
    m.clr_i = 1'b1;
    tick("t4.clr_en");
    check("t4.clr_col", 32'(m.col_o), 32'd0);
    check("t4.clr_fd", 32'(m.frame_done_o), 32'd0);
    m.clr_i = 1'b0;
    repeat (5) tick("t4.run");
    rstn = 1'b0;
    tick("t4.rst_en");
    check("t4.rst_col", 32'(m.col_o), 32'd0);
    check("t4.rst_row", 32'(m.row_o), 32'd0);
    rstn = 1'b1;
    m.en_i = 1'b0;

    // Degenerate 1x1 frame: every pixel ends a frame
    m.col_max_i = '0;
    m.row_max_i = '0;
    m.clr_i = 1'b1;
    tick("t5.clr");
    m.clr_i = 1'b0;
    check("t5.sof", 32'(m.sof_o), 32'd1);
    check("t5.eof", 32'(m.eof_o), 32'd1);
    check("t5.fd_before", 32'(m.frame_done_o), 32'd0);
    m.en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t5.run");
      check($sformatf("t5.fd%0d", i), 32'(m.frame_done_o), 32'd1);
      check($sformatf("t5.eol%0d", i), 32'(m.eol_o), 32'd1);
    end
`ifdef RASTER_COUNTER_FRAME_CNT_EN
    check("t6.fcnt_final", 32'(m.frame_cnt_o), 32'd1);
`endif
    m.en_i = 1'b0;
    tick("t5.idle");
    check("t5.idle_fd", 32'(m.frame_done_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/raster_counter.md
Name: raster_counter

Overview:
Two-axis (column/row) pixel-position counter for the streaming image path.
- Column axis advances on each accepted pixel; row axis advances on column wrap.
- Emits start/end-of-line and start/end-of-frame markers, plus a frame-done pulse.
- Feeds the line buffers and Sobel window logic with coordinates and border flags. Frame size is set at runtime, up to the parameter bounds.

Parameters:
COL_WIDTH_P, 11, bit width of column counter / col_max_i (max 2048 columns)
ROW_WIDTH_P, 11, bit width of row counter / row_max_i
SATURATE_P, 0, 0 = wrap to (0,0) after last pixel; 1 = hold at last pixel until clr_i
FRAME_CNT_WIDTH_P, 16, width of frame counter (optional feature only)

Ports:
clk_i  input  1  clock, all state on posedge
rstn_i  input  1  synchronous active-low reset
en_i  input  1  advance one pixel this cycle
clr_i  input  1  synchronous clear to (0,0); reloads limits
col_max_i  input  COL_WIDTH_P  last column index (columns-1)
row_max_i  input  ROW_WIDTH_P  last row index (rows-1)
col_o  output  COL_WIDTH_P  current column
row_o  output  ROW_WIDTH_P  current row
sol_o  output  1  col_o==0
eol_o  output  1  col_o==latched col limit
sof_o  output  1  col_o==0 && row_o==0
eof_o  output  1  eol_o && row_o==latched row limit
frame_done_o  output  1  one-cycle pulse after last pixel accepted
done_o  output  1  sticky hold flag (SATURATE_P=1 only, else tied 0)

Behaviour:
- Reset (rstn_i=0): col/row=0, frame_done_o=0, done_o=0; col_max_i/row_max_i latched into internal limit registers.
- Limits relatched on reset, on clr_i, and on the cycle the frame wraps (en_i at eof). Mid-frame changes to col_max_i/row_max_i have no effect until then.
- Priority, highest first: rstn_i, clr_i, en_i.
- clr_i with en_i: clear wins; no advance, no pulse; done_o cleared.
- en_i=1, not eol: col+1, row unchanged.
- en_i=1, eol, not eof: col=0, row+1.
- en_i=1, eof:
  - SATURATE_P=0: col=0, row=0, limits relatched.
  - SATURATE_P=1: position held, done_o set.
  - Both modes: frame_done_o=1 on the next cycle for exactly one cycle.
- done_o=1 (saturate): en_i ignored, frame_done_o never re-pulses; only clr_i or reset resume counting.
- sol/eol/sof/eof are combinational from registered state and latched limits; 0-cycle latency relative to col_o/row_o.
- Degenerate limits:
  - col limit 0: eol_o permanently 1; row advances every en_i.
  - both limits 0: sof_o=eof_o=1 and every en_i produces frame_done_o.
- All arithmetic unsigned. Counters never exceed latched limits, so no overflow beyond limit.
- A limit input at all-ones is legal (full 2^W range).
- en_i low: all outputs hold, except frame_done_o, which deasserts after its single cycle.

Optional Feature:
RASTER_COUNTER_FRAME_CNT_EN
- Defined: adds output frame_cnt_o [FRAME_CNT_WIDTH_P-1:0].
  - Reset and clr_i set it to 0.
  - Increments in the same cycle frame_done_o asserts.
  - Wraps from all-ones to 0.
  - Saturate mode: increments once per hold.
- Undefined: port absent, no register inferred.

Decomposition:
- Package raster_counter_pkg:
  - border-flag struct typedef {sol, eol, sof, eof}
  - localparam default widths
  - localparam mode encodings SAT_MODE_WRAP=0, SAT_MODE_HOLD=1
- One sub-module, axis_counter (instantiated twice: column and row):
  - Parameter WIDTH_P.
  - Inputs: clk_i, rstn_i, clr_i, en_i, limit_i.
  - Outputs: count_o, at_limit_o (combinational); wraps to 0 on en_i at limit.
  - Column instance en = en_i && !hold.
  - Row instance en = en_i && eol && !hold.
- Limit latching, frame_done/done logic and the optional frame counter live in the top.

Test Plan:
1. Reset with col_max_i=3, row_max_i=2, then 12 cycles en_i=1.
   - Required: col sequence 0,1,2,3,0…; row advances on each eol; eof_o at (3,2).
   - frame_done_o pulses on cycle 13; position back at (0,0).
2. Mid-frame at (1,1), change col_max_i 3→5.
   - Required: current frame still wraps at col 3; next frame counts to col 5.
3. SATURATE_P=1, limits (1,1), 6 en_i pulses.
   - Required: holds at (1,1) after 4th pulse; done_o=1; single frame_done_o pulse.
   - clr_i then returns (0,0) and done_o=0.
4. clr_i and en_i together at (2,1).
   - Required: (0,0) next cycle, no frame_done_o; same with rstn_i=0 mid-frame.
5. Limits (0,0), en_i every cycle for 4 cycles.
   - Required: sof_o=eof_o=sol_o=eol_o=1 constantly; frame_done_o high 4 consecutive cycles starting cycle 2.
6. RASTER_COUNTER_FRAME_CNT_EN defined, FRAME_CNT_WIDTH_P=2, limits (0,0), 5 en_i.
   - Required: frame_cnt_o 1,2,3,0,1.
